// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: single-cycle hits, line refill over a
// request handshake plus an ascending beat stream, deferred flush, and hit/miss counters.
module instr_cache #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_rsp_valid,
  output logic [31:0]       cpu_rsp_instr,
  output logic              cpu_rsp_fault,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int unsigned IdxW  = $clog2(NUM_LINES);
  localparam int unsigned WordW = $clog2(LINE_WORDS);
  localparam int unsigned OffW  = WordW + 2;
  localparam int unsigned TagW  = ADDR_W - IdxW - OffW;

  typedef enum logic [1:0] {StIdle, StReq, StFill, StResp} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:2]   addr_q;
  logic [WordW-1:0]    beat_q;
  logic [31:0]         word_q;
  logic                flush_pend_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TagW-1:0]     tag_q  [NUM_LINES];
  logic [31:0]         data_q [NUM_LINES][LINE_WORDS];
  logic                rsp_valid_q, rsp_fault_q;
  logic [31:0]         rsp_instr_q;
  logic [31:0]         hit_q, miss_q;

  logic [TagW-1:0]  req_tag, fill_tag;
  logic [IdxW-1:0]  req_idx, fill_idx;
  logic [WordW-1:0] req_word, fill_word;
  logic             ready, accept, misaligned, hit, beat_in, last_beat;

  assign req_tag    = cpu_req_addr[ADDR_W-1 -: TagW];
  assign req_idx    = cpu_req_addr[OffW +: IdxW];
  assign req_word   = cpu_req_addr[2 +: WordW];
  assign fill_tag   = addr_q[ADDR_W-1 -: TagW];
  assign fill_idx   = addr_q[OffW +: IdxW];
  assign fill_word  = addr_q[2 +: WordW];

  assign ready      = (state_q == StIdle) && !flush && !flush_pend_q && !rst;
  assign accept     = cpu_req_valid && ready;
  assign misaligned = |cpu_req_addr[1:0];
  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign beat_in    = (state_q == StFill) && mem_rsp_valid;
  assign last_beat  = beat_in && (beat_q == WordW'(LINE_WORDS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && !misaligned && !hit) state_d = StReq;
      StReq:   if (mem_req_ready) state_d = StFill;
      StFill:  if (last_beat) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      beat_q       <= '0;
      word_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_fault_q  <= 1'b0;
      rsp_instr_q  <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_instr_q <= '0;
      if (accept) begin
        if (misaligned) begin
          rsp_valid_q <= 1'b1;
          rsp_fault_q <= 1'b1;
        end else if (hit) begin
          rsp_valid_q <= 1'b1;
          rsp_instr_q <= data_q[req_idx][req_word];
          hit_q       <= hit_q + 32'd1;
        end else begin
          miss_q <= miss_q + 32'd1;
          addr_q <= cpu_req_addr[ADDR_W-1:2];
        end
      end
      if (beat_in) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == fill_word) word_q <= mem_rsp_data;
        // Response is registered here so it appears in the RESP cycle.
        if (last_beat) begin
          valid_q[fill_idx] <= 1'b1;
          rsp_valid_q       <= 1'b1;
          rsp_instr_q       <= (beat_q == fill_word) ? mem_rsp_data : word_q;
        end
      end
      if ((state_q == StIdle) && (flush || flush_pend_q)) begin
        valid_q      <= '0;
        flush_pend_q <= 1'b0;
      end else if (flush) begin
        flush_pend_q <= 1'b1;
      end
    end
  end

  // Storage arrays need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst && beat_in) begin
      data_q[fill_idx][beat_q] <= mem_rsp_data;
      if (last_beat) tag_q[fill_idx] <= fill_tag;
    end
  end

  assign cpu_req_ready = ready;
  assign cpu_rsp_valid = rsp_valid_q && !rst;
  assign cpu_rsp_fault = rsp_fault_q && !rst;
  assign cpu_rsp_instr = rst ? 32'd0 : rsp_instr_q;
  assign mem_req_valid = (state_q == StReq) && !rst;
  assign mem_req_addr  = rst ? '0 : {addr_q[ADDR_W-1:OffW], {OffW{1'b0}}};
  assign hit_cnt       = rst ? 32'd0 : hit_q;
  assign miss_cnt      = rst ? 32'd0 : miss_q;

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios plus randomized fetches
// compared against a line-address cache model over a fixed memory image.
module tb_instr_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic [31:0] cpu_req_addr = '0;
  logic        flush = 1'b0;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        cpu_req_ready, cpu_rsp_valid, cpu_rsp_fault, mem_req_valid;
  logic [31:0] cpu_rsp_instr, mem_req_addr, hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  instr_cache #(.ADDR_W(32), .NUM_LINES(16), .LINE_WORDS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_ready (cpu_req_ready),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_instr (cpu_rsp_instr),
    .cpu_rsp_fault (cpu_rsp_fault),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Backing memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h1) return 32'hA0 + {28'd0, a[3:2]};
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder, acting 1ns after each rising edge.
  int          mphase = 0, mcnt = 0, mbeat = 0;
  int          mem_reqs = 0, mem_wait = 0, gaps = 0, addr_unstable = 0;
  logic [31:0] maddr = '0, last_mem_addr = '0;

  always begin
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (rst) begin
      mphase = 0;
    end else begin
      if (mphase == 0 && mem_req_valid) begin
        mem_reqs++;
        maddr = mem_req_addr;
        last_mem_addr = mem_req_addr;
        mcnt = mem_wait;
        mphase = 1;
      end
      if (mphase == 1) begin
        if (!mem_req_valid || mem_req_addr != maddr) addr_unstable++;
        if (mcnt == 0) begin
          mem_req_ready = 1'b1;
          mphase = 2;
          mbeat = 0;
        end else begin
          mcnt--;
        end
      end else if (mphase == 2 && (gaps == 0 || $urandom_range(0, 3) != 0)) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(maddr + 32'(4 * mbeat));
        mbeat++;
        if (mbeat == 4) mphase = 0;
      end
    end
  end

  // Reference model: which line address each slot holds, plus expected counters.
  bit          m_vld  [16];
  logic [27:0] m_line [16];
  logic [31:0] exp_hit = '0, exp_miss = '0;

  function automatic bit m_hit(input logic [31:0] a);
    return m_vld[a[7:4]] && (m_line[a[7:4]] == a[31:4]);
  endfunction

  task automatic m_fill(input logic [31:0] a);
    m_vld[a[7:4]] = 1'b1;
    m_line[a[7:4]] = a[31:4];
  endtask

  task automatic m_clear();
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
  endtask

  // Issue one fetch starting at a falling edge; returns at the response (or timeout).
  task automatic fetch(input logic [31:0] a, output logic got, output logic [31:0] ins,
                       output logic flt, output int lat);
    int n = 0;
    while (!cpu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    lat = 1;
    while (!cpu_rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    got = cpu_rsp_valid;
    ins = cpu_rsp_instr;
    flt = cpu_rsp_fault;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cpu_req_ready, cpu_rsp_valid, cpu_rsp_fault, mem_req_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 0000",
               {cpu_req_ready, cpu_rsp_valid, cpu_rsp_fault, mem_req_valid});
    end
    checks++;
    if ({cpu_rsp_instr, mem_req_addr, hit_cnt, miss_cnt} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data got %h required 0",
               {cpu_rsp_instr, mem_req_addr, hit_cnt, miss_cnt});
    end
    rst = 1'b0;
    m_clear();
    exp_hit = 0;
    exp_miss = 0;
    @(negedge clk);
    checks++;
    if (cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 1", cpu_req_ready);
    end
  endtask

  task automatic test_cold_miss();
    logic got, flt;
    logic [31:0] ins;
    int lat, r0;
    mem_wait = 2;
    gaps = 0;
    r0 = mem_reqs;
    fetch(32'h10, got, ins, flt, lat);
    checks++;
    if ({got, flt, ins} !== {2'b10, 32'hA0}) begin
      errors++;
      $display("FAIL cold_rsp got v%b f%b %h required v1 f0 a0", got, flt, ins);
    end
    checks++;
    if (mem_reqs - r0 != 1 || last_mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL cold_memreq got n%0d addr %h required n1 addr 10",
               mem_reqs - r0, last_mem_addr);
    end
    m_fill(32'h10);
    exp_miss++;
    checks++;
    if (miss_cnt !== exp_miss || hit_cnt !== exp_hit) begin
      errors++;
      $display("FAIL cold_counts got h%0d m%0d required h%0d m%0d",
               hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int r0 = mem_reqs;
    while (!cpu_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      cpu_req_valid = 1'b1;
      cpu_req_addr  = 32'h14 + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (cpu_rsp_valid !== 1'b1 || cpu_rsp_instr !== 32'hA1 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_rsp%0d got v%b %h required v1 %h", i, cpu_rsp_valid,
                 cpu_rsp_instr, 32'hA1 + 32'(i));
      end
      checks++;
      if (cpu_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d got %b required 1", i, cpu_req_ready);
      end
    end
    cpu_req_valid = 1'b0;
    exp_hit += 3;
    checks++;
    if (hit_cnt !== exp_hit || mem_reqs != r0) begin
      errors++;
      $display("FAIL b2b_counts got h%0d memreqs %0d required h%0d memreqs 0",
               hit_cnt, mem_reqs - r0, exp_hit);
    end
  endtask

  task automatic test_evict();
    logic got, flt;
    logic [31:0] ins, a;
    int lat, r0;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 32'h110 : 32'h10;
      r0 = mem_reqs;
      fetch(a, got, ins, flt, lat);
      checks++;
      if (got !== 1'b1 || ins !== mem_word(a) || mem_reqs - r0 != 1 || last_mem_addr !== a) begin
        errors++;
        $display("FAIL evict_%h got v%b %h n%0d addr %h required v1 %h n1 addr %h",
                 a, got, ins, mem_reqs - r0, last_mem_addr, mem_word(a), a);
      end
      m_fill(a);
      exp_miss++;
    end
    checks++;
    if (miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL evict_misscnt got %0d required %0d", miss_cnt, exp_miss);
    end
  endtask

  task automatic test_misaligned();
    logic got, flt;
    logic [31:0] ins;
    int lat;
    int r0 = mem_reqs;
    fetch(32'h2, got, ins, flt, lat);
    checks++;
    if ({got, flt, ins} !== {2'b11, 32'd0} || lat != 1) begin
      errors++;
      $display("FAIL misaligned_rsp got v%b f%b %h lat%0d required v1 f1 0 lat1",
               got, flt, ins, lat);
    end
    checks++;
    if (hit_cnt !== exp_hit || miss_cnt !== exp_miss || mem_reqs != r0) begin
      errors++;
      $display("FAIL misaligned_side got h%0d m%0d n%0d required h%0d m%0d n0",
               hit_cnt, miss_cnt, mem_reqs - r0, exp_hit, exp_miss);
    end
  endtask

  task automatic test_flush_idle();
    logic got, flt;
    logic [31:0] ins;
    int lat, r0;
    int n = 0;
    while (!cpu_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    flush = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h10;
    #1;
    checks++;
    if (cpu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_ready got %b required 0", cpu_req_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    cpu_req_valid = 1'b0;
    checks++;
    if (cpu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_noaccept got rsp%b memreq%b required 0 0",
               cpu_rsp_valid, mem_req_valid);
    end
    m_clear();
    r0 = mem_reqs;
    fetch(32'h10, got, ins, flt, lat);
    checks++;
    if (got !== 1'b1 || ins !== 32'hA0 || mem_reqs - r0 != 1) begin
      errors++;
      $display("FAIL flush_idle_refetch got v%b %h n%0d required v1 a0 n1",
               got, ins, mem_reqs - r0);
    end
    m_fill(32'h10);
    exp_miss++;
  endtask

  task automatic test_flush_mid_fill();
    logic got, flt;
    logic [31:0] ins;
    int lat, r0, n;
    mem_wait = 1;
    gaps = 0;
    n = 0;
    while (!cpu_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    r0 = mem_reqs;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h220;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (mphase != 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (!cpu_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp_miss++;
    checks++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_instr !== mem_word(32'h220)) begin
      errors++;
      $display("FAIL flush_fill_rsp got v%b %h required v1 %h", cpu_rsp_valid,
               cpu_rsp_instr, mem_word(32'h220));
    end
    @(negedge clk);
    checks++;
    if (cpu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_fill_apply_ready got %b required 0", cpu_req_ready);
    end
    @(negedge clk);
    checks++;
    if (cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_fill_after_ready got %b required 1", cpu_req_ready);
    end
    m_clear();
    r0 = mem_reqs;
    fetch(32'h220, got, ins, flt, lat);
    fetch(32'h10, got, ins, flt, lat);
    exp_miss += 2;
    m_fill(32'h220);
    m_fill(32'h10);
    checks++;
    if (mem_reqs - r0 != 2 || miss_cnt !== exp_miss || ins !== 32'hA0) begin
      errors++;
      $display("FAIL flush_fill_refetch got n%0d m%0d %h required n2 m%0d a0",
               mem_reqs - r0, miss_cnt, ins, exp_miss);
    end
  endtask

  task automatic test_random();
    logic got, flt;
    logic [31:0] ins, a;
    int lat, r0;
    bit exp_h, mis;
    gaps = 1;
    for (int i = 0; i < 300; i++) begin
      mem_wait = $urandom_range(0, 3);
      if ($urandom_range(0, 11) == 0) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_clear();
      end
      mis = ($urandom_range(0, 7) == 0);
      a = {20'd0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), mis ? 2'($urandom_range(1, 3)) : 2'b00};
      if ($urandom_range(0, 15) == 0) a[31:12] = 20'($urandom);
      exp_h = !mis && m_hit(a);
      r0 = mem_reqs;
      fetch(a, got, ins, flt, lat);
      if (mis) begin
        checks++;
        if ({got, flt, ins} !== {2'b11, 32'd0} || lat != 1 || mem_reqs != r0) begin
          errors++;
          $display("FAIL rnd_fault a=%h got v%b f%b %h lat%0d n%0d", a, got, flt, ins, lat,
                   mem_reqs - r0);
        end
      end else if (exp_h) begin
        exp_hit++;
        checks++;
        if ({got, flt, ins} !== {2'b10, mem_word(a)} || lat != 1 || mem_reqs != r0) begin
          errors++;
          $display("FAIL rnd_hit a=%h got v%b f%b %h lat%0d n%0d required %h lat1 n0",
                   a, got, flt, ins, lat, mem_reqs - r0, mem_word(a));
        end
      end else begin
        exp_miss++;
        m_fill(a);
        checks++;
        if ({got, flt, ins} !== {2'b10, mem_word(a)} || mem_reqs - r0 != 1 ||
            last_mem_addr !== {a[31:4], 4'b0}) begin
          errors++;
          $display("FAIL rnd_miss a=%h got v%b f%b %h n%0d addr %h required %h n1",
                   a, got, flt, ins, mem_reqs - r0, last_mem_addr, mem_word(a));
        end
      end
      checks++;
      if (hit_cnt !== exp_hit || miss_cnt !== exp_miss) begin
        errors++;
        $display("FAIL rnd_counts a=%h got h%0d m%0d required h%0d m%0d",
                 a, hit_cnt, miss_cnt, exp_hit, exp_miss);
      end
    end
    checks++;
    if (addr_unstable != 0) begin
      errors++;
      $display("FAIL memreq_stable got %0d unstable cycles required 0", addr_unstable);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic got, flt;
    logic [31:0] ins;
    int lat, r0, n;
    mem_wait = 0;
    gaps = 0;
    n = 0;
    while (!cpu_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h3C4;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (mphase != 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({cpu_req_ready, cpu_rsp_valid, cpu_rsp_fault, mem_req_valid, cpu_rsp_instr,
         mem_req_addr, hit_cnt, miss_cnt} !== 132'd0) begin
      errors++;
      $display("FAIL rst_fill_outputs got %h required 0", {cpu_req_ready, cpu_rsp_valid,
               cpu_rsp_fault, mem_req_valid, cpu_rsp_instr, mem_req_addr, hit_cnt, miss_cnt});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_clear();
    exp_hit = 0;
    exp_miss = 0;
    @(negedge clk);
    r0 = mem_reqs;
    fetch(32'h3C4, got, ins, flt, lat);
    checks++;
    if (got !== 1'b1 || ins !== mem_word(32'h3C4) || mem_reqs - r0 != 1 ||
        miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_fill_refetch got v%b %h n%0d h%0d m%0d required v1 %h n1 h0 m1",
               got, ins, mem_reqs - r0, hit_cnt, miss_cnt, mem_word(32'h3C4));
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_evict();
    test_misaligned();
    test_flush_idle();
    test_flush_mid_fill();
    test_random();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
